// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and op-class helper functions.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // DIV/DIVU/REM/REMU all live in the upper half of the funct3 space
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed by MUL, MULH, MULHSU, DIV, REM
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV, REM
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, or
// trial-subtract/shift (restoring) for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] p,      // product accumulator, or {rem, quo}
  input  logic [2*XLEN-1:0] s,      // shifted multiplicand, or divisor in low half
  input  logic [XLEN-1:0]   m,      // remaining multiplier bits
  output logic [2*XLEN-1:0] p_n,
  output logic [2*XLEN-1:0] s_n,
  output logic [XLEN-1:0]   m_n
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Single iteration; diff MSB set means the trial subtraction borrowed
  always_comb begin
    p_n    = p;
    s_n    = s;
    m_n    = m;
    rem_sh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff   = rem_sh - {1'b0, s[XLEN-1:0]};
    if (is_div) begin
      if (!diff[XLEN]) p_n = {diff[XLEN-1:0],   p[XLEN-2:0], 1'b1};
      else             p_n = {rem_sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
    end else begin
      if (m[0]) p_n = p + s;
      s_n = {s[2*XLEN-2:0], 1'b0};
      m_n = {1'b0, m[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the execute stage.
// Operands are reduced to magnitudes at accept, iterated XLEN times through
// muldiv_step, then the sign is restored in a single SIGN cycle.
// Optional: define MULDIV_EARLY_OUT_EN to let multiplies leave CALC as soon
// as the remaining multiplier bits are all zero.
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] p_q, p_d, s_q, s_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] p_n, s_n;
  logic [XLEN-1:0]   m_n;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, sel;
  logic [2*XLEN-1:0] prod_fix;
  logic              calc_last;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div(f3_q)),
    .p      (p_q),
    .s      (s_q),
    .m      (m_q),
    .p_n    (p_n),
    .s_n    (s_n),
    .m_n    (m_n)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt_q == CW'(XLEN-1)) || (!is_div(f3_q) && (m_n == '0));
`else
  assign calc_last = (cnt_q == CW'(XLEN-1));
`endif

  // Next-state, operand conditioning, iteration and sign restore
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    p_d      = p_q;
    s_d      = s_q;
    m_d      = m_q;
    result_d = result_q;
    a_neg    = is_signed_a(funct3) & op_a[XLEN-1];
    b_neg    = is_signed_b(funct3) & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    prod_fix = neg_q ? -p_q : p_q;
    sel      = f3_q[1] ? p_q[2*XLEN-1:XLEN] : p_q[XLEN-1:0];

    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        f3_d  = funct3;
        cnt_d = '0;
        if (is_div(funct3)) begin
          p_d   = {{XLEN{1'b0}}, a_mag};
          s_d   = {{XLEN{1'b0}}, b_mag};
          m_d   = '0;
          neg_d = funct3[1] ? a_neg : (a_neg ^ b_neg);  // REM follows dividend
        end else begin
          p_d   = '0;
          s_d   = {{XLEN{1'b0}}, a_mag};
          m_d   = b_mag;
          neg_d = a_neg ^ b_neg;
        end
        // Divide-by-zero and signed overflow resolve without iterating
        if (is_div(funct3) && op_b == '0) begin
          result_d = funct3[1] ? op_a : '1;
          state_d  = ST_DONE;
        end else if (is_div(funct3) && !funct3[0] && op_a == SMIN && op_b == '1) begin
          result_d = funct3[1] ? '0 : op_a;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        p_d   = p_n;
        s_d   = s_n;
        m_d   = m_n;
        cnt_d = cnt_q + CW'(1);
        if (calc_last) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        if (!is_div(f3_q))
          result_d = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
          result_d = neg_q ? -sel : sel;
        state_d = ST_DONE;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle accept
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // FSM and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      s_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      s_q      <= s_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign stall     = (state_q != ST_IDLE) && !((state_q == ST_DONE) && out_ready);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: hand-computed results and latencies,
// fast paths, flush, async reset mid-op and writeback backpressure.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        stall;

  int vecs = 0;
  int errs = 0;

  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept->out_valid latency, check result, consume it
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    if (out_ready) begin
      chk({tag, "_stall_consume"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    #23;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_result",    result,         32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("divu_by0",   3'd5, 32'd100,      32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_by0",   3'd7, 32'd100,      32'd0,         32'd100,       1);
    run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("divu_100_7", 3'd5, 32'd100,      32'd7,         32'd14,        34);

    // Flush during CALC: abort, back to IDLE, never produce a result
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("calc_stall",    32'(stall),    32'd1);
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    chk("flush_stall",     32'(stall),     32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Flush beats a same-cycle accept
    funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_vs_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("flush_vs_accept_ov", 32'(out_valid), 32'd0);

    // Async reset mid-op returns to reset values immediately
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_stall",    32'(stall),    32'd0);
    chk("arst_result",   result,        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("arst_no_result", 32'(seen), 32'd0);

    // Backpressure in DONE: result held, stall high until consumed
    out_ready = 1'b0;
    run_op("hold_divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid",  32'(out_valid), 32'd1);
      chk("hold_result", result,         32'd14);
      chk("hold_stall",  32'(stall),     32'd1);
      chk("hold_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("consume_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("consume_idle",  32'(in_ready),  32'd1);
    chk("consume_ov",    32'(out_valid), 32'd0);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
